// File: rtl/alarm_bank.sv
// Multi-channel HH:MM:SS alarm bank with per-channel ring/snooze/dismiss FSM.
// Matches against the running time on each sec_tick and drives the alarm LED.
module alarm_bank #(
  parameter int N_ALARMS    = 4,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int IDX_W       = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sec_tick,
  input  logic [4:0]          H_OUT,
  input  logic [5:0]          M_OUT,
  input  logic [5:0]          S_OUT,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [4:0]          wr_h,
  input  logic [5:0]          wr_m,
  input  logic [5:0]          wr_s,
  input  logic                wr_arm,
  input  logic                snooze,
  input  logic                dismiss,
  output logic                wr_ack,
  output logic                wr_err,
  output logic [N_ALARMS-1:0] armed_vec,
  output logic [N_ALARMS-1:0] ring_vec,
  output logic [N_ALARMS-1:0] snz_vec,
  output logic                OUT_LED
);

  localparam int CNT_MAX =
    (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int SU_W =
    (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [CNT_W-1:0] RING_INIT = CNT_W'(RING_SECS);
  localparam logic [CNT_W-1:0] SNZ_INIT  = CNT_W'(SNOOZE_SECS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [SU_W-1:0]  SU_MAX    = SU_W'(MAX_SNOOZE);
  localparam logic [SU_W-1:0]  SU_ONE    = SU_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RING = 2'd1,
    SNZ  = 2'd2
  } st_t;

  st_t              st_q [N_ALARMS];
  st_t              st_d [N_ALARMS];
  logic [4:0]       ah_q [N_ALARMS];
  logic [4:0]       ah_d [N_ALARMS];
  logic [5:0]       am_q [N_ALARMS];
  logic [5:0]       am_d [N_ALARMS];
  logic [5:0]       as_q [N_ALARMS];
  logic [5:0]       as_d [N_ALARMS];
  logic [CNT_W-1:0] rc_q [N_ALARMS];
  logic [CNT_W-1:0] rc_d [N_ALARMS];
  logic [CNT_W-1:0] sc_q [N_ALARMS];
  logic [CNT_W-1:0] sc_d [N_ALARMS];
  logic [SU_W-1:0]  su_q [N_ALARMS];
  logic [SU_W-1:0]  su_d [N_ALARMS];
  logic [N_ALARMS-1:0] arm_q;
  logic [N_ALARMS-1:0] arm_d;

  logic                wr_ok;
  logic [N_ALARMS-1:0] wr_sel;
  logic [N_ALARMS-1:0] match;

  assign wr_ok = wr_en
              && (wr_h <= 5'd23)
              && (wr_m <= 6'd59)
              && (wr_s <= 6'd59)
              && (int'(wr_idx) < N_ALARMS);

  always_comb begin
    wr_sel = '0;
    match  = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      wr_sel[i] = wr_ok && (int'(wr_idx) == i);
      match[i]  = sec_tick && arm_q[i]
               && (H_OUT == ah_q[i])
               && (M_OUT == am_q[i])
               && (S_OUT == as_q[i]);
    end
  end

  // A write to a channel overrides every other event in that cycle.
  always_comb begin
    arm_d = arm_q;
    for (int i = 0; i < N_ALARMS; i++) begin
      st_d[i] = st_q[i];
      ah_d[i] = ah_q[i];
      am_d[i] = am_q[i];
      as_d[i] = as_q[i];
      rc_d[i] = rc_q[i];
      sc_d[i] = sc_q[i];
      su_d[i] = su_q[i];
      if (wr_sel[i]) begin
        ah_d[i]  = wr_h;
        am_d[i]  = wr_m;
        as_d[i]  = wr_s;
        arm_d[i] = wr_arm;
        st_d[i]  = IDLE;
        su_d[i]  = '0;
      end else begin
        unique case (st_q[i])
          IDLE: begin
            if (match[i]) begin
              st_d[i] = RING;
              rc_d[i] = RING_INIT;
              su_d[i] = '0;
            end
          end
          RING: begin
            if (dismiss) begin
              st_d[i] = IDLE;
            end else if (snooze && (su_q[i] < SU_MAX)) begin
              st_d[i] = SNZ;
              sc_d[i] = SNZ_INIT;
              su_d[i] = su_q[i] + SU_ONE;
            end else if (sec_tick) begin
              if (rc_q[i] == CNT_ONE) st_d[i] = IDLE;
              else rc_d[i] = rc_q[i] - CNT_ONE;
            end
          end
          SNZ: begin
            if (dismiss) begin
              st_d[i] = IDLE;
            end else if (sec_tick) begin
              if (sc_q[i] == CNT_ONE) begin
                st_d[i] = RING;
                rc_d[i] = RING_INIT;
              end else begin
                sc_d[i] = sc_q[i] - CNT_ONE;
              end
            end
          end
          default: st_d[i] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arm_q <= '0;
      for (int i = 0; i < N_ALARMS; i++) begin
        st_q[i] <= IDLE;
        ah_q[i] <= '0;
        am_q[i] <= '0;
        as_q[i] <= '0;
        rc_q[i] <= '0;
        sc_q[i] <= '0;
        su_q[i] <= '0;
      end
    end else begin
      arm_q <= arm_d;
      for (int i = 0; i < N_ALARMS; i++) begin
        st_q[i] <= st_d[i];
        ah_q[i] <= ah_d[i];
        am_q[i] <= am_d[i];
        as_q[i] <= as_d[i];
        rc_q[i] <= rc_d[i];
        sc_q[i] <= sc_d[i];
        su_q[i] <= su_d[i];
      end
    end
  end

  always_comb begin
    ring_vec  = '0;
    snz_vec   = '0;
    armed_vec = arm_q;
    for (int i = 0; i < N_ALARMS; i++) begin
      ring_vec[i] = (st_q[i] == RING);
      snz_vec[i]  = (st_q[i] == SNZ);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ack  <= 1'b0;
      wr_err  <= 1'b0;
      OUT_LED <= 1'b0;
    end else begin
      wr_ack  <= wr_ok;
      wr_err  <= wr_en && !wr_ok;
      OUT_LED <= |ring_vec;
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Bench for alarm_bank: directed scenarios plus randomized traffic
// checked against a seconds-based behavioural model.
module tb_alarm_bank;

  localparam int N   = 4;
  localparam int IW  = 3;
  localparam int RS  = 60;
  localparam int SS  = 300;
  localparam int MS  = 3;
  localparam int W   = 3 * N + 3;
  localparam int DAY = 86400;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sec_tick = 1'b0;
  logic [4:0]    H_OUT = '0;
  logic [5:0]    M_OUT = '0;
  logic [5:0]    S_OUT = '0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_idx = '0;
  logic [4:0]    wr_h = '0;
  logic [5:0]    wr_m = '0;
  logic [5:0]    wr_s = '0;
  logic          wr_arm = 1'b0;
  logic          snooze = 1'b0;
  logic          dismiss = 1'b0;
  logic          wr_ack;
  logic          wr_err;
  logic [N-1:0]  armed_vec;
  logic [N-1:0]  ring_vec;
  logic [N-1:0]  snz_vec;
  logic          OUT_LED;

  alarm_bank #(
    .N_ALARMS(N), .RING_SECS(RS), .SNOOZE_SECS(SS),
    .MAX_SNOOZE(MS), .IDX_W(IW)
  ) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick),
    .H_OUT(H_OUT), .M_OUT(M_OUT), .S_OUT(S_OUT),
    .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_h(wr_h), .wr_m(wr_m), .wr_s(wr_s),
    .wr_arm(wr_arm), .snooze(snooze), .dismiss(dismiss),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .armed_vec(armed_vec), .ring_vec(ring_vec),
    .snz_vec(snz_vec), .OUT_LED(OUT_LED)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int tsec = 0;

  // Model: alarm time in seconds of day, mode 0 idle/1 ring/2 snooze,
  // seconds left in the current mode, snoozes used.
  int m_t    [N];
  bit m_arm  [N];
  int m_mode [N];
  int m_left [N];
  int m_used [N];
  bit e_led, e_ack, e_err;

  wire [W-1:0] act = {ring_vec, snz_vec, armed_vec,
                      OUT_LED, wr_ack, wr_err};

  function automatic int hms(int h, int m, int s);
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic logic [W-1:0] exp_bus();
    logic [N-1:0] r, s, a;
    for (int c = 0; c < N; c++) begin
      r[c] = (m_mode[c] == 1);
      s[c] = (m_mode[c] == 2);
      a[c] = m_arm[c];
    end
    return {r, s, a, e_led, e_ack, e_err};
  endfunction

  task automatic model_step();
    bit any, ok;
    int now, wt, wi;
    any = 0;
    for (int c = 0; c < N; c++) any |= (m_mode[c] == 1);
    if (reset) begin
      for (int c = 0; c < N; c++) begin
        m_t[c] = 0; m_arm[c] = 0; m_mode[c] = 0;
        m_left[c] = 0; m_used[c] = 0;
      end
      e_led = 0; e_ack = 0; e_err = 0;
      return;
    end
    wi = int'(wr_idx);
    ok = wr_en && int'(wr_h) <= 23 && int'(wr_m) <= 59
      && int'(wr_s) <= 59 && wi < N;
    wt = hms(int'(wr_h), int'(wr_m), int'(wr_s));
    now = hms(int'(H_OUT), int'(M_OUT), int'(S_OUT));
    e_led = any;
    e_ack = ok;
    e_err = wr_en && !ok;
    for (int c = 0; c < N; c++) begin
      if (ok && wi == c) begin
        m_t[c] = wt; m_arm[c] = wr_arm;
        m_mode[c] = 0; m_used[c] = 0;
      end else if (m_mode[c] == 0) begin
        if (sec_tick && m_arm[c] && now == m_t[c]) begin
          m_mode[c] = 1; m_left[c] = RS; m_used[c] = 0;
        end
      end else if (dismiss) begin
        m_mode[c] = 0;
      end else if (m_mode[c] == 1 && snooze && m_used[c] < MS) begin
        m_mode[c] = 2; m_left[c] = SS; m_used[c]++;
      end else if (sec_tick) begin
        m_left[c]--;
        if (m_left[c] == 0) begin
          if (m_mode[c] == 1) m_mode[c] = 0;
          else begin m_mode[c] = 1; m_left[c] = RS; end
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    sec_tick = 0; wr_en = 0; snooze = 0; dismiss = 0;
  endtask

  task automatic set_time(int t);
    tsec = t;
    H_OUT = 5'(t / 3600);
    M_OUT = 6'((t / 60) % 60);
    S_OUT = 6'(t % 60);
  endtask

  task automatic tick();
    set_time((tsec + 1) % DAY);
    sec_tick = 1;
    step();
  endtask

  task automatic tick_at(int t);
    set_time(t);
    sec_tick = 1;
    step();
  endtask

  task automatic drive_wr(int idx, int h, int m, int s, bit arm);
    wr_en = 1; wr_idx = IW'(idx);
    wr_h = 5'(h); wr_m = 6'(m); wr_s = 6'(s); wr_arm = arm;
  endtask

  task automatic do_write(int idx, int h, int m, int s, bit arm);
    drive_wr(idx, h, m, s, arm);
    step();
  endtask

  task automatic test_reset();
    reset = 1;
    step(); step();
    reset = 0;
    n_chk++;
    if (act !== '0) $display("FAIL reset_outputs got=%h want=0", act);
    else n_pass++;
    step();
    n_chk++;
    if (act !== exp_bus())
      $display("FAIL reset_hold got=%h want=%h", act, exp_bus());
    else n_pass++;
  endtask

  task automatic test_ring_autostop();
    do_write(0, 7, 0, 5, 1);
    n_chk++;
    if (wr_ack !== 1'b1 || armed_vec !== 4'b0001)
      $display("FAIL t1_write ack=%b arm=%b want 1/0001",
               wr_ack, armed_vec);
    else n_pass++;
    set_time(hms(7, 0, 4));
    step();
    tick_at(hms(7, 0, 5));
    n_chk++;
    if (ring_vec !== 4'b0001 || OUT_LED !== 1'b0)
      $display("FAIL t1_ring ring=%b led=%b want 0001/0",
               ring_vec, OUT_LED);
    else n_pass++;
    step();
    n_chk++;
    if (OUT_LED !== 1'b1)
      $display("FAIL t1_led got=%b want=1", OUT_LED);
    else n_pass++;
    for (int k = 1; k <= RS; k++) begin
      tick();
      n_chk++;
      if (ring_vec[0] !== (k < RS))
        $display("FAIL t1_autostop tick=%0d got=%b want=%b",
                 k, ring_vec[0], (k < RS));
      else n_pass++;
    end
    n_chk++;
    if (act !== exp_bus())
      $display("FAIL t1_end got=%h want=%h", act, exp_bus());
    else n_pass++;
  endtask

  task automatic test_snooze();
    do_write(1, 9, 0, 0, 1);
    tick_at(hms(9, 0, 0));
    n_chk++;
    if (ring_vec[1] !== 1'b1)
      $display("FAIL t2_ring got=%b want=1", ring_vec[1]);
    else n_pass++;
    for (int r = 0; r < MS; r++) begin
      snooze = 1;
      step();
      n_chk++;
      if (snz_vec[1] !== 1'b1 || ring_vec[1] !== 1'b0)
        $display("FAIL t2_snooze n=%0d snz=%b ring=%b want 1/0",
                 r, snz_vec[1], ring_vec[1]);
      else n_pass++;
      for (int k = 1; k <= SS; k++) begin
        tick();
        n_chk++;
        if (act !== exp_bus() || ring_vec[1] !== (k == SS))
          $display("FAIL t2_wait n=%0d tick=%0d got=%h want=%h",
                   r, k, act, exp_bus());
        else n_pass++;
      end
    end
    snooze = 1;
    step();
    n_chk++;
    if (ring_vec[1] !== 1'b1 || snz_vec[1] !== 1'b0)
      $display("FAIL t2_extra_snooze ring=%b snz=%b want 1/0",
               ring_vec[1], snz_vec[1]);
    else n_pass++;
    dismiss = 1;
    step();
  endtask

  task automatic test_dismiss();
    do_write(0, 10, 0, 0, 1);
    do_write(2, 10, 0, 0, 1);
    tick_at(hms(10, 0, 0));
    n_chk++;
    if (ring_vec !== 4'b0101)
      $display("FAIL t3_ring got=%b want=0101", ring_vec);
    else n_pass++;
    step();
    dismiss = 1;
    step();
    n_chk++;
    if (ring_vec !== 4'b0000 || OUT_LED !== 1'b1)
      $display("FAIL t3_dismiss ring=%b led=%b want 0000/1",
               ring_vec, OUT_LED);
    else n_pass++;
    step();
    n_chk++;
    if (OUT_LED !== 1'b0)
      $display("FAIL t3_led_fall got=%b want=0", OUT_LED);
    else n_pass++;
  endtask

  task automatic test_write_err();
    int bi [5] = '{1, 1, 1, 4, 7};
    int bh [5] = '{24, 5, 5, 5, 5};
    int bm [5] = '{0, 60, 0, 0, 0};
    int bs [5] = '{0, 0, 60, 0, 0};
    logic [N-1:0] a;
    a = armed_vec;
    for (int k = 0; k < 5; k++) begin
      do_write(bi[k], bh[k], bm[k], bs[k], 0);
      n_chk++;
      if (wr_err !== 1'b1 || wr_ack !== 1'b0 || armed_vec !== a)
        $display("FAIL t4_reject n=%0d err=%b ack=%b arm=%b want 1/0/%b",
                 k, wr_err, wr_ack, armed_vec, a);
      else n_pass++;
    end
    do_write(3, 23, 59, 59, 1);
    n_chk++;
    if (wr_ack !== 1'b1 || wr_err !== 1'b0 || armed_vec[3] !== 1'b1)
      $display("FAIL t4_accept ack=%b err=%b arm=%b want 1/0/1",
               wr_ack, wr_err, armed_vec[3]);
    else n_pass++;
    step();
    n_chk++;
    if (wr_ack !== 1'b0 || wr_err !== 1'b0)
      $display("FAIL t4_pulse ack=%b err=%b want 0/0", wr_ack, wr_err);
    else n_pass++;
  endtask

  task automatic test_write_match();
    do_write(3, 11, 0, 0, 1);
    drive_wr(3, 12, 0, 0, 1);
    tick_at(hms(11, 0, 0));
    n_chk++;
    if (ring_vec[3] !== 1'b0 || wr_ack !== 1'b1)
      $display("FAIL t5_collide ring=%b ack=%b want 0/1",
               ring_vec[3], wr_ack);
    else n_pass++;
    tick_at(hms(11, 0, 0));
    n_chk++;
    if (ring_vec[3] !== 1'b0)
      $display("FAIL t5_old_time got=%b want=0", ring_vec[3]);
    else n_pass++;
    tick_at(hms(12, 0, 0));
    n_chk++;
    if (ring_vec[3] !== 1'b1)
      $display("FAIL t5_new_time got=%b want=1", ring_vec[3]);
    else n_pass++;
    dismiss = 1;
    step();
  endtask

  task automatic test_reset_snooze();
    do_write(0, 13, 0, 0, 1);
    tick_at(hms(13, 0, 0));
    snooze = 1;
    step();
    n_chk++;
    if (snz_vec[0] !== 1'b1)
      $display("FAIL t6_snooze got=%b want=1", snz_vec[0]);
    else n_pass++;
    reset = 1;
    step();
    reset = 0;
    n_chk++;
    if (act !== '0) $display("FAIL t6_reset got=%h want=0", act);
    else n_pass++;
    tick_at(hms(13, 0, 0));
    step();
    n_chk++;
    if (ring_vec !== '0 || OUT_LED !== 1'b0)
      $display("FAIL t6_no_ring ring=%b led=%b want 0/0",
               ring_vec, OUT_LED);
    else n_pass++;
    do_write(0, 13, 0, 0, 1);
    tick_at(hms(13, 0, 0));
    n_chk++;
    if (ring_vec !== 4'b0001)
      $display("FAIL t6_rearm got=%b want=0001", ring_vec);
    else n_pass++;
    dismiss = 1;
    step();
  endtask

  task automatic test_random();
    int pool [4];
    int t;
    pool[0] = hms(6, 30, 0);
    pool[1] = hms(6, 30, 1);
    pool[2] = hms(23, 59, 59);
    pool[3] = hms(0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) begin
        t = pool[$urandom_range(0, 3)];
        drive_wr($urandom_range(0, 5), t / 3600, (t / 60) % 60,
                 t % 60, $urandom_range(0, 3) != 0);
        case ($urandom_range(0, 9))
          0: wr_h = 5'd24;
          1: wr_m = 6'd60;
          2: wr_s = 6'd60;
          default: ;
        endcase
      end
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 3) == 0)
          set_time(pool[$urandom_range(0, 3)]);
        else set_time((tsec + 1) % DAY);
        sec_tick = 1;
      end
      snooze = ($urandom_range(0, 19) == 0);
      dismiss = ($urandom_range(0, 79) == 0);
      step();
      n_chk++;
      if (act !== exp_bus())
        $display("FAIL random cyc=%0d got=%h want=%h",
                 n, act, exp_bus());
      else n_pass++;
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_ring_autostop();
    test_snooze();
    test_dismiss();
    test_write_err();
    test_write_match();
    test_reset_snooze();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
